// File: rtl/regfile_wr_arbiter_pkg.sv
// rtl/regfile_wr_arbiter_pkg.sv - requester indices, default sizes and write-command type
package regfile_wr_arbiter_pkg;
  localparam int NREQ_DEFAULT = 3;
  localparam int DW_DEFAULT   = 8;
  localparam int AW_DEFAULT   = 2;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_IMM = 2;

  typedef struct packed {
    logic                  we;
    logic [AW_DEFAULT-1:0] addr;
    logic [DW_DEFAULT-1:0] data;
  } rf_wr_cmd_t;
endpackage

// File: rtl/regfile_wr_arbiter_rr_picker.sv
// rtl/regfile_wr_arbiter_rr_picker.sv - combinational one-hot grant selection
// REGFILE_ARB_RR_EN selects round-robin from last+1; otherwise the lowest index wins.
module rr_picker
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT
) (
  input  logic [NREQ-1:0] valid,
  input  logic [1:0]      last,
  output logic [NREQ-1:0] grant
);

`ifdef REGFILE_ARB_RR_EN
  // Step k visits requester (last+1+k) mod NREQ; the first valid one found wins.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && valid[i] && (i == (int'(last) + 1 + k) % NREQ)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && valid[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - arbitrates writeback sources onto the register file write port
// Arbitration mode is chosen by REGFILE_ARB_RR_EN (round-robin when defined, fixed priority otherwise).
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int DW   = DW_DEFAULT,
  parameter int AW   = AW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rf_regwrite,
  output logic [AW-1:0]     rf_writereg,
  output logic [DW-1:0]     rf_data,
  output logic [1:0]        grant_id,
  output logic [15:0]       wr_count
);

  logic [1:0]      last;
  logic [NREQ-1:0] grant;
  logic [1:0]      sel_id;
  rf_wr_cmd_t      cmd;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .valid (req_valid),
    .last  (last),
    .grant (grant)
  );

  // The picker only grants valid requesters, so a ready bit is already a transfer.
  assign req_ready = (stall || reset) ? '0 : grant;

  always_comb begin
    cmd    = '0;
    sel_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        cmd.we   = 1'b1;
        cmd.addr = req_addr[i*AW +: AW];
        cmd.data = req_data[i*DW +: DW];
        sel_id   = 2'(i);
      end
    end
  end

  // Rising-edge update keeps the command stable across the register file's falling-edge write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_regwrite <= 1'b0;
      rf_writereg <= '0;
      rf_data     <= '0;
      grant_id    <= 2'(REQ_ALU);
      wr_count    <= '0;
      last        <= 2'(NREQ - 1);
    end else begin
      rf_regwrite <= cmd.we;
      if (cmd.we) begin
        rf_writereg <= cmd.addr;
        rf_data     <= cmd.data;
        grant_id    <= sel_id;
        last        <= sel_id;
        wr_count    <= wr_count + 16'd1;
      end
    end
  end

endmodule
